bp_gshare_predictor: RTL and testbench

- Fetch-side gshare conditional-branch predictor.
- Reads the 2-bit pattern history table (PHT) to produce taken/not-taken predictions, and keeps a speculative global history register (GHR).
- Accepts execute-stage resolutions, which train the PHT through the shared pht_inc/pht_dec saturating-counter functions and repair the GHR on mispredict.
- Sits between the fetch PC generator and the branch resolution unit.

---
 rtl/bp_gshare_predictor_pkg.sv | 25 ++
 rtl/bp_gshare_predictor_if.sv | 37 +++
 rtl/bp_gshare_predictor_pht_array.sv | 61 ++++++
 rtl/bp_gshare_predictor.sv | 125 ++++++++++++
 tb/tb_bp_gshare_predictor.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/bp_gshare_predictor_pkg.sv
// Shared branch-predictor types and helpers: the 2-bit saturating counter
// type, its increment/decrement functions and the predictor FSM states.
package cpu_modules;

    typedef logic [1:0] bp_cnt_t;

    // Weakly not-taken: the value every PHT entry holds after the init sweep.
    localparam bp_cnt_t BP_CNT_WNT = 2'b01;

    typedef enum logic {
        BP_INIT = 1'b0,
        BP_RUN  = 1'b1
    } bp_state_t;

    // Saturating increment toward strongly taken.
    function automatic bp_cnt_t pht_inc(bp_cnt_t cnt);
        return (cnt == 2'b11) ? cnt : cnt + 2'b01;
    endfunction

    // Saturating decrement toward strongly not-taken.
    function automatic bp_cnt_t pht_dec(bp_cnt_t cnt);
        return (cnt == 2'b00) ? cnt : cnt - 2'b01;
    endfunction

endpackage

// File: rtl/bp_gshare_predictor_if.sv
// Fetch/resolve interface of the gshare predictor.
//
// Handshake: a lookup transfers in any cycle where lookup_valid_i and
// lookup_ready_o are both high; the fetch side may drop or change its
// request freely while ready is low. The prediction comes back as a
// one-cycle pred_valid_o pulse with no back-pressure. Resolutions
// (upd_valid_i) are fire-and-forget and are never stalled.
interface bp_gshare_predictor_if #(
    parameter int XLEN  = 64,
    parameter int GHR_W = 8
);
    logic             lookup_valid_i;
    logic [XLEN-1:0]  lookup_pc_i;
    logic             lookup_ready_o;
    logic             pred_valid_o;
    logic             pred_taken_o;
    logic [GHR_W-1:0] pred_ghr_o;
    logic             upd_valid_i;
    logic [XLEN-1:0]  upd_pc_i;
    logic [GHR_W-1:0] upd_ghr_i;
    logic             upd_taken_i;
    logic             upd_mispredict_i;

    // Fetch/resolve side.
    modport master (
        output lookup_valid_i, lookup_pc_i,
        output upd_valid_i, upd_pc_i, upd_ghr_i, upd_taken_i, upd_mispredict_i,
        input  lookup_ready_o, pred_valid_o, pred_taken_o, pred_ghr_o
    );

    // Predictor side.
    modport slave (
        input  lookup_valid_i, lookup_pc_i,
        input  upd_valid_i, upd_pc_i, upd_ghr_i, upd_taken_i, upd_mispredict_i,
        output lookup_ready_o, pred_valid_o, pred_taken_o, pred_ghr_o
    );
endinterface

// File: rtl/bp_gshare_predictor_pht_array.sv
// Pattern history table storage: 2^IDX_W saturating counters with one
// registered read port and one read-modify-write port. The write port
// either loads the weakly-not-taken init value or trains the addressed
// counter up/down. Storage has no reset; the owner sweeps it after reset.
// Optional macro BP_BYPASS_EN: a read colliding with a same-cycle write
// returns the freshly written counter instead of the old one.
module bp_pht_array
    import cpu_modules::*;
#(
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_idx,
    output bp_cnt_t          rd_cnt,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_init,
    input  logic             wr_taken
);

    bp_cnt_t mem [2**IDX_W];
    bp_cnt_t wr_cnt;
    bp_cnt_t rd_next;

    // New value for the write port: init constant or trained counter.
    always_comb begin
        if (wr_init) begin
            wr_cnt = BP_CNT_WNT;
        end else if (wr_taken) begin
            wr_cnt = pht_inc(mem[wr_idx]);
        end else begin
            wr_cnt = pht_dec(mem[wr_idx]);
        end
    end

    // Read data selection; the bypass forwards a colliding write.
    always_comb begin
        rd_next = mem[rd_idx];
`ifdef BP_BYPASS_EN
        if (wr_en && (wr_idx == rd_idx)) begin
            rd_next = wr_cnt;
        end
`endif
    end

    // Counter storage write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_cnt;
        end
    end

    // Registered read port, only updated on an accepted lookup.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_cnt <= rd_next;
        end
    end

endmodule

// File: rtl/bp_gshare_predictor.sv
// Gshare conditional-branch predictor. After reset an INIT sweep writes
// every PHT entry to weakly not-taken (one per cycle), then the block runs:
// lookups index the PHT with PC xor speculative global history and return a
// prediction one cycle later; resolutions train the PHT and, on mispredict,
// repair the history and flush the in-flight prediction.
// Optional macro BP_BYPASS_EN (in bp_pht_array): same-cycle update/lookup on
// one entry predicts from the updated counter.
module bp_gshare_predictor
    import cpu_modules::*;
#(
    parameter int PHT_IDX_W = 8,
    parameter int GHR_W     = 8,
    parameter int XLEN      = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bp_gshare_predictor_if.slave  bp,
    output bp_state_t             dbg_state_o
);

    bp_state_t              state;
    logic [PHT_IDX_W-1:0]   ptr;
    logic                   ready_q;
    logic                   pred_valid_q;
    logic [GHR_W-1:0]       pred_ghr_q;
    logic [GHR_W-1:0]       ghr;
    logic [GHR_W-1:0]       ghr_eff;
    logic [PHT_IDX_W-1:0]   idx;
    logic [PHT_IDX_W-1:0]   uidx;
    logic                   run;
    logic                   lookup_fire;
    logic                   upd_fire;
    logic                   repair;
    logic                   pred_taken;
    bp_cnt_t                rd_cnt;
    logic                   unused_pc_bits;

    assign run         = (state == BP_RUN);
    assign lookup_fire = bp.lookup_valid_i && ready_q;
    assign upd_fire    = bp.upd_valid_i && run;
    assign repair      = upd_fire && bp.upd_mispredict_i;

    // Read data is only meaningful while the prediction is valid; masking
    // keeps pred_taken_o at zero through reset without resetting storage.
    assign pred_taken = pred_valid_q & rd_cnt[1];

    // Fold the in-flight prediction into the history for back-to-back lookups.
    assign ghr_eff = pred_valid_q ? {ghr[GHR_W-2:0], pred_taken} : ghr;
    assign idx     = bp.lookup_pc_i[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr_eff);
    assign uidx    = bp.upd_pc_i[PHT_IDX_W+1:2] ^ PHT_IDX_W'(bp.upd_ghr_i);

    // PC bits outside the index field do not take part in prediction.
    assign unused_pc_bits = ^{bp.lookup_pc_i[XLEN-1:PHT_IDX_W+2], bp.lookup_pc_i[1:0],
                              bp.upd_pc_i[XLEN-1:PHT_IDX_W+2], bp.upd_pc_i[1:0]};

    bp_pht_array #(
        .IDX_W (PHT_IDX_W)
    ) u_pht (
        .clk      (clk),
        .rd_en    (lookup_fire),
        .rd_idx   (idx),
        .rd_cnt   (rd_cnt),
        .wr_en    (!run || upd_fire),
        .wr_idx   (run ? uidx : ptr),
        .wr_init  (!run),
        .wr_taken (bp.upd_taken_i)
    );

    // Init sweep / run FSM with registered ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= BP_INIT;
            ptr     <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state)
                BP_INIT: begin
                    ptr <= ptr + PHT_IDX_W'(1);
                    if (&ptr) begin
                        state   <= BP_RUN;
                        ready_q <= 1'b1;
                    end
                end
                BP_RUN: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= BP_INIT;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Prediction pulse and the history it was indexed with.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid_q <= 1'b0;
            pred_ghr_q   <= '0;
        end else begin
            pred_valid_q <= lookup_fire && !repair;
            if (lookup_fire) begin
                pred_ghr_q <= ghr_eff;
            end
        end
    end

    // Speculative history: mispredict repair wins over committing a prediction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr <= '0;
        end else if (repair) begin
            ghr <= {bp.upd_ghr_i[GHR_W-2:0], bp.upd_taken_i};
        end else if (pred_valid_q) begin
            ghr <= {ghr[GHR_W-2:0], pred_taken};
        end
    end

    assign bp.lookup_ready_o = ready_q;
    assign bp.pred_valid_o   = pred_valid_q;
    assign bp.pred_taken_o   = pred_taken;
    assign bp.pred_ghr_o     = pred_ghr_q;
    assign dbg_state_o       = state;

endmodule

// File: tb/tb_bp_gshare_predictor.sv
// Self-checking bench for bp_gshare_predictor: directed scenarios with
// hand-computed results, randomized traffic against a table/integer model,
// and an asynchronous reset in the middle of traffic.
module tb_bp_gshare_predictor;
    import cpu_modules::*;

    localparam int N = 256;

    logic      clk = 1'b0;
    logic      rst_n = 1'b0;
    bp_state_t dbg_state;

    bp_gshare_predictor_if bp_if ();

    bp_gshare_predictor dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bp          (bp_if),
        .dbg_state_o (dbg_state)
    );

    // Clock generation.
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: counters as plain ints, history as an int.
    int m_pht [N];
    bit m_run;
    int m_cnt;
    bit m_pv;
    bit m_pt;
    int m_ghr;
    int m_pg;

    // Model step at each clock edge, then compare the DUT just after it.
    always @(posedge clk) begin : model_cmp
        int eff, idx, uidx, cur, nxt;
        bit acc, flush, npt;
        if (!rst_n) begin
            m_run = 0; m_cnt = 0; m_pv = 0; m_pt = 0; m_pg = 0; m_ghr = 0;
        end else if (!m_run) begin
            m_cnt++;
            m_pv = 0;
            if (m_cnt == N) begin
                foreach (m_pht[i]) m_pht[i] = 1;
                m_run = 1;
            end
        end else begin
            eff   = m_pv ? (((m_ghr << 1) | int'(m_pt)) & 255) : m_ghr;
            acc   = bp_if.lookup_valid_i;
            flush = bp_if.upd_valid_i && bp_if.upd_mispredict_i;
            idx   = int'((bp_if.lookup_pc_i >> 2) & 64'hFF) ^ eff;
            uidx  = int'((bp_if.upd_pc_i >> 2) & 64'hFF) ^ int'(bp_if.upd_ghr_i);
            cur   = m_pht[uidx];
            if (bp_if.upd_taken_i) nxt = (cur == 3) ? 3 : cur + 1;
            else                   nxt = (cur == 0) ? 0 : cur - 1;
            npt = (m_pht[idx] >= 2);
`ifdef BP_BYPASS_EN
            if (bp_if.upd_valid_i && (uidx == idx)) npt = (nxt >= 2);
`endif
            if (flush) m_ghr = ((int'(bp_if.upd_ghr_i) << 1) | int'(bp_if.upd_taken_i)) & 255;
            else if (m_pv) m_ghr = eff;
            if (bp_if.upd_valid_i) m_pht[uidx] = nxt;
            if (acc) begin
                m_pg = eff;
                m_pt = npt;
            end
            m_pv = acc && !flush;
        end
        #1;
        check("state", dbg_state, m_run ? BP_RUN : BP_INIT);
        check("ready", bp_if.lookup_ready_o, m_run);
        check("pred_valid", bp_if.pred_valid_o, m_pv);
        if (m_pv) begin
            check("pred_taken", bp_if.pred_taken_o, m_pt);
            check("pred_ghr", bp_if.pred_ghr_o, m_pg);
        end
    end

    // Drive one cycle of inputs, return 2 time units after the sampling edge.
    task automatic cyc(bit lv, logic [63:0] pc, bit uv, logic [63:0] upc,
                       logic [7:0] ughr, bit ut, bit um);
        bp_if.lookup_valid_i   = lv;
        bp_if.lookup_pc_i      = pc;
        bp_if.upd_valid_i      = uv;
        bp_if.upd_pc_i         = upc;
        bp_if.upd_ghr_i        = ughr;
        bp_if.upd_taken_i      = ut;
        bp_if.upd_mispredict_i = um;
        @(posedge clk);
        #2;
    endtask

    task automatic rand_cyc();
        logic [63:0] pc, upc;
        pc  = {$urandom, $urandom};
        upc = ($urandom_range(0, 3) == 0) ? pc : {$urandom, $urandom};
        cyc($urandom_range(0, 3) != 0, pc, $urandom_range(0, 1) == 1, upc,
            8'($urandom_range(0, 255)), $urandom_range(0, 1) == 1,
            $urandom_range(0, 4) == 0);
    endtask

    // Count edges until lookup_ready_o rises, bounded.
    task automatic wait_init(string name);
        int n;
        n = 0;
        while (1) begin
            @(posedge clk);
            #2;
            n++;
            if (bp_if.lookup_ready_o === 1'b1) break;
            if (n >= 1000) break;
        end
        check(name, n, N);
    endtask

    initial begin
        bp_if.lookup_valid_i   = 1'b0;
        bp_if.lookup_pc_i      = '0;
        bp_if.upd_valid_i      = 1'b0;
        bp_if.upd_pc_i         = '0;
        bp_if.upd_ghr_i        = '0;
        bp_if.upd_taken_i      = 1'b0;
        bp_if.upd_mispredict_i = 1'b0;

        repeat (3) @(posedge clk);
        #2;
        check("rst_pred_valid", bp_if.pred_valid_o, 0);
        check("rst_pred_taken", bp_if.pred_taken_o, 0);
        check("rst_pred_ghr", bp_if.pred_ghr_o, 0);
        check("rst_ready", bp_if.lookup_ready_o, 0);
        rst_n = 1'b1;
        wait_init("init_cycles");

        // First lookup after init: weakly not-taken, history 0.
        cyc(1, 64'h1000, 0, 0, 8'h00, 0, 0);
        check("first_valid", bp_if.pred_valid_o, 1);
        check("first_taken", bp_if.pred_taken_o, 0);
        check("first_ghr", bp_if.pred_ghr_o, 0);

        // Train entry 0 twice taken: 01 -> 10 -> 11.
        cyc(0, 0, 1, 64'h1000, 8'h00, 1, 0);
        cyc(0, 0, 1, 64'h1000, 8'h00, 1, 0);
        cyc(1, 64'h1000, 0, 0, 8'h00, 0, 0);
        check("trained_taken", bp_if.pred_taken_o, 1);
        check("trained_ghr", bp_if.pred_ghr_o, 0);

        // Third taken saturates at 11; one not-taken leaves 10 (still taken).
        cyc(0, 0, 1, 64'h1000, 8'h00, 1, 0);
        cyc(0, 0, 1, 64'h1000, 8'h00, 0, 0);
        cyc(1, 64'h1004, 0, 0, 8'h00, 0, 0);
        check("saturate_taken", bp_if.pred_taken_o, 1);
        check("saturate_ghr", bp_if.pred_ghr_o, 8'h01);

        // Repair history to 0 (mispredict, not-taken) with no lookup.
        cyc(0, 0, 1, 64'h1100, 8'h00, 0, 1);

        // Back-to-back lookups: the second sees the first's taken prediction.
        cyc(1, 64'h1000, 0, 0, 8'h00, 0, 0);
        check("b2b_first_taken", bp_if.pred_taken_o, 1);
        check("b2b_first_ghr", bp_if.pred_ghr_o, 0);
        cyc(1, 64'h1004, 0, 0, 8'h00, 0, 0);
        check("b2b_second_ghr", bp_if.pred_ghr_o, 8'h01);
        check("b2b_second_taken", bp_if.pred_taken_o, 1);
        cyc(0, 0, 0, 0, 8'h00, 0, 0);
        cyc(1, 64'h1000, 0, 0, 8'h00, 0, 0);
        check("b2b_commit_ghr", bp_if.pred_ghr_o, 8'h03);

        // Mispredict in the same cycle as a lookup and a pending prediction.
        cyc(1, 64'h1000, 1, 64'h1200, 8'h05, 1, 1);
        check("flush_no_pred", bp_if.pred_valid_o, 0);
        cyc(1, 64'h1000, 0, 0, 8'h00, 0, 0);
        check("repair_ghr", bp_if.pred_ghr_o, 8'h0B);

        // Same-cycle update and lookup on entry 0x16 (holding 01).
        cyc(0, 0, 0, 0, 8'h00, 0, 0);
        cyc(1, 64'h1000, 1, 64'h1000, 8'h16, 1, 0);
        check("collision_ghr", bp_if.pred_ghr_o, 8'h16);
`ifdef BP_BYPASS_EN
        check("collision_taken", bp_if.pred_taken_o, 1);
`else
        check("collision_taken", bp_if.pred_taken_o, 0);
`endif

        // Randomized traffic.
        repeat (3000) rand_cyc();

        // Asynchronous reset in the middle of traffic.
        rand_cyc();
        rst_n = 1'b0;
        #1;
        check("midrst_pred_valid", bp_if.pred_valid_o, 0);
        check("midrst_pred_taken", bp_if.pred_taken_o, 0);
        check("midrst_pred_ghr", bp_if.pred_ghr_o, 0);
        check("midrst_ready", bp_if.lookup_ready_o, 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        wait_init("reinit_cycles");
        repeat (600) rand_cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
